rr_arb_mux_pipe: RTL

//  N-channel round-robin arbiter fused with a one-hot AND-OR payload mux and a

---
 rtl/rr_arb_mux_pkg.sv | 21 ++
 rtl/rr_arb_onehot.sv | 25 ++
 rtl/rr_arb_mux_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbiter/mux slice.
// The optional packet lock (RR_ARB_MUX_LOCK_EN) is handled in rr_arb_mux_pipe.
package rr_arb_mux_pkg;

   localparam int RST_PTR_LSB = 1;
   localparam int RR_MAX_W    = 32;

   // Reference round-robin pick for up to RR_MAX_W requesters; unused upper bits must be 0.
   function automatic logic [RR_MAX_W-1:0] rr_first_onehot(
      input logic [RR_MAX_W-1:0] req,
      input logic [RR_MAX_W-1:0] ptr
   );
      logic [RR_MAX_W-1:0] masked;
      masked = req & ~(ptr - RR_MAX_W'(1));
      if (|masked)
         return masked & (~masked + RR_MAX_W'(1));
      else
         return req & (~req + RR_MAX_W'(1));
   endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin picker: first set bit of req at or above the
// one-hot ptr, wrapping to bit 0, computed on a double-width request vector.
module rr_arb_onehot #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] ptr,
   output logic [WIDTH-1:0] grant
);

   logic [WIDTH-1:0]   below_ptr;
   logic [WIDTH-1:0]   masked;
   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] dbl_low;

   assign below_ptr = ptr - WIDTH'(1);
   assign masked    = req & ~below_ptr;

   // Lower half holds requests at/above ptr, upper half the wrapped full set;
   // isolating the lowest set bit picks from the upper half only if the lower is empty.
   assign dbl       = {req, masked};
   assign dbl_low   = dbl & ~(dbl - (2*WIDTH)'(1));
   assign grant     = dbl_low[WIDTH-1:0] | dbl_low[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rr_arb_mux_pipe.sv
// Round-robin arbiter + one-hot AND-OR payload mux + 1-deep output register.
// Define RR_ARB_MUX_LOCK_EN to hold the grant on one channel until v_last.
module rr_arb_mux_pipe
   import rr_arb_mux_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int PLD_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     v_vld,
   output logic [WIDTH-1:0]     v_rdy,
   input  logic [PLD_WIDTH-1:0] v_pld [WIDTH-1:0],
   input  logic [WIDTH-1:0]     v_last,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [PLD_WIDTH-1:0] out_pld,
   output logic [WIDTH-1:0]     out_sel,
   output logic                 out_last
);

   logic [WIDTH-1:0]     prio_ptr_reg;
   logic [WIDTH-1:0]     arb_grant;
   logic [WIDTH-1:0]     grant;
   logic [WIDTH-1:0]     ptr_next;
   logic                 slot_free;
   logic                 acc;
   logic                 acc_last;
   logic [PLD_WIDTH-1:0] gated_pld [WIDTH-1:0];
   logic [PLD_WIDTH-1:0] mux_pld;

   logic                 out_vld_reg;
   logic [PLD_WIDTH-1:0] out_pld_reg;
   logic [WIDTH-1:0]     out_sel_reg;
   logic                 out_last_reg;

   rr_arb_onehot #(.WIDTH(WIDTH)) u_arb (
      .req   (v_vld),
      .ptr   (prio_ptr_reg),
      .grant (arb_grant)
   );

`ifdef RR_ARB_MUX_LOCK_EN
   logic             lock_reg;
   logic [WIDTH-1:0] lock_sel_reg;

   assign grant = lock_reg ? (lock_sel_reg & v_vld) : arb_grant;
`else
   assign grant = arb_grant;
`endif

   assign slot_free = ~out_vld_reg | out_rdy;
   assign v_rdy     = grant & {WIDTH{slot_free}};
   assign acc       = |(v_vld & v_rdy);
   assign acc_last  = |(v_last & grant);
   assign ptr_next  = {grant[WIDTH-2:0], grant[WIDTH-1]};

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_gate
         assign gated_pld[gi] = v_pld[gi] & {PLD_WIDTH{grant[gi]}};
      end
   endgenerate

   always_comb begin
      mux_pld = '0;
      for (int i = 0; i < WIDTH; i++)
         mux_pld = mux_pld | gated_pld[i];
   end

   // Output slice: load on accept, drop valid when a beat drains with nothing behind it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_reg  <= 1'b0;
         out_pld_reg  <= '0;
         out_sel_reg  <= '0;
         out_last_reg <= 1'b0;
      end else if (acc) begin
         out_vld_reg  <= 1'b1;
         out_pld_reg  <= mux_pld;
         out_sel_reg  <= grant;
         out_last_reg <= acc_last;
      end else if (out_rdy) begin
         out_vld_reg  <= 1'b0;
      end
   end

`ifdef RR_ARB_MUX_LOCK_EN
   // Mid-packet beats keep the lock and freeze the pointer; the last beat rotates it.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_ptr_reg <= WIDTH'(RST_PTR_LSB);
         lock_reg     <= 1'b0;
         lock_sel_reg <= '0;
      end else if (acc) begin
         lock_reg     <= ~acc_last;
         lock_sel_reg <= grant;
         if (acc_last)
            prio_ptr_reg <= ptr_next;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst)
         prio_ptr_reg <= WIDTH'(RST_PTR_LSB);
      else if (acc)
         prio_ptr_reg <= ptr_next;
   end
`endif

   assign out_vld  = out_vld_reg;
   assign out_pld  = out_pld_reg;
   assign out_sel  = out_sel_reg;
   assign out_last = out_last_reg;

endmodule
